// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the pipelined multiplier:
// bias derivation, field extraction, flag bundle, NaN/inf constants.
package fp_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Result class decided in S1; only CLS_NORM needs the multiply path.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_t;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic logic fp_sign(input word_t w, input int ew,
                                     input int mw);
        return w[ew + mw];
    endfunction

    function automatic word_t fp_exp(input word_t w, input int ew,
                                     input int mw);
        return (w >> mw) & ((word_t'(1) << ew) - word_t'(1));
    endfunction

    function automatic word_t fp_man(input word_t w, input int mw);
        return w & ((word_t'(1) << mw) - word_t'(1));
    endfunction

    // Canonical NaN: sign 0, exponent all ones, mantissa MSB only.
    function automatic word_t fp_nan(input int ew, input int mw);
        return (((word_t'(1) << ew) - word_t'(1)) << mw)
             | (word_t'(1) << (mw - 1));
    endfunction

    function automatic word_t fp_inf(input logic s, input int ew,
                                     input int mw);
        return (word_t'(s) << (ew + mw))
             | (((word_t'(1) << ew) - word_t'(1)) << mw);
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational S3: normalise, round-to-nearest-even and pack.
// Ports: sign/cls/e/prod from S2 in; packed res and 4-bit flags out.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                       sign,
    input  logic [1:0]                 cls,
    input  logic signed [EXP_W+1:0]    e,
    input  logic [2*MAN_W+1:0]         prod,
    output logic [EXP_W+MAN_W:0]       res,
    output logic [3:0]                 flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int PW  = 2 * MAN_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EZERO = '0;

    fp_cls_t                cls_e;
    logic [2*MAN_W:0]       sh;
    logic [MAN_W-1:0]       man;
    logic                   guard;
    logic                   sticky;
    logic                   rnd;
    logic [MAN_W:0]         man_r;
    logic signed [EW2-1:0]  e_n;
    logic signed [EW2-1:0]  e_f;
    fp_flags_t              fl;

    always_comb begin
        cls_e  = fp_cls_t'(cls);
        // Drop the leading one; a set MSB means the product is in [2,4).
        sh     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        e_n    = e + EW2'(prod[PW-1]);
        man    = sh[2*MAN_W -: MAN_W];
        guard  = sh[MAN_W];
        sticky = |sh[MAN_W-1:0];
        rnd    = guard & (sticky | man[0]);
        // Carry out of the rounded mantissa leaves man=0 and bumps e.
        man_r  = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
        e_f    = e_n + EW2'(man_r[MAN_W]);
        res    = '0;
        fl     = '0;
        unique case (cls_e)
            CLS_NAN: begin
                res        = W'(fp_nan(EXP_W, MAN_W));
                fl.invalid = 1'b1;
            end
            CLS_INF: begin
                res = W'(fp_inf(sign, EXP_W, MAN_W));
            end
            CLS_ZERO: begin
                res = {sign, {(EXP_W+MAN_W){1'b0}}};
            end
            default: begin
                if (e_f >= EMAX) begin
                    res         = W'(fp_inf(sign, EXP_W, MAN_W));
                    fl.overflow = 1'b1;
                    fl.inexact  = 1'b1;
                end else if (e_f <= EZERO) begin
                    res          = {sign, {(EXP_W+MAN_W){1'b0}}};
                    fl.underflow = 1'b1;
                    fl.inexact   = 1'b1;
                end else begin
                    res        = {sign, e_f[EXP_W-1:0], man_r[MAN_W-1:0]};
                    fl.inexact = guard | sticky;
                end
            end
        endcase
        flags = fl;
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-style multiplier with valid/ready flow control and tag.
// Ports: clock/reset_n, in_valid/in_ready/opA/opB/in_tag in,
//        out_valid/out_ready/product/out_tag/flags out.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opA,
    input  logic [EXP_W+MAN_W:0]   opB,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = fp_bias(EXP_W);

    logic                  stall;
    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, a_inf, a_nan;
    logic                  b_zero, b_inf, b_nan;
    fp_cls_t               cls_in;
    logic [EW2-1:0]        e_in;

    logic                  s1_v_d, s1_v_q;
    logic [TAG_W-1:0]      s1_tag_d, s1_tag_q;
    logic                  s1_sign_d, s1_sign_q;
    fp_cls_t               s1_cls_d, s1_cls_q;
    logic [MW1-1:0]        s1_ma_d, s1_ma_q;
    logic [MW1-1:0]        s1_mb_d, s1_mb_q;
    logic signed [EW2-1:0] s1_e_d, s1_e_q;

    logic                  s2_v_d, s2_v_q;
    logic [TAG_W-1:0]      s2_tag_d, s2_tag_q;
    logic                  s2_sign_d, s2_sign_q;
    fp_cls_t               s2_cls_d, s2_cls_q;
    logic signed [EW2-1:0] s2_e_d, s2_e_q;
    logic [PW-1:0]         s2_prod_d, s2_prod_q;

    logic                  out_valid_d, out_valid_q;
    logic [W-1:0]          product_d, product_q;
    logic [TAG_W-1:0]      out_tag_d, out_tag_q;
    logic [3:0]            flags_d, flags_q;

    logic [W-1:0]          rp_res;
    logic [3:0]            rp_flags;

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign  (s2_sign_q),
        .cls   (s2_cls_q),
        .e     (s2_e_q),
        .prod  (s2_prod_q),
        .res   (rp_res),
        .flags (rp_flags)
    );

    // S1 unpack and classify; exp==0 is flushed to zero.
    always_comb begin
        sa     = fp_sign(word_t'(opA), EXP_W, MAN_W);
        sb     = fp_sign(word_t'(opB), EXP_W, MAN_W);
        ea     = EXP_W'(fp_exp(word_t'(opA), EXP_W, MAN_W));
        eb     = EXP_W'(fp_exp(word_t'(opB), EXP_W, MAN_W));
        fa     = MAN_W'(fp_man(word_t'(opA), MAN_W));
        fb     = MAN_W'(fp_man(word_t'(opB), MAN_W));
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            cls_in = CLS_NAN;
        else if (a_inf || b_inf)
            cls_in = CLS_INF;
        else if (a_zero || b_zero)
            cls_in = CLS_ZERO;
        else
            cls_in = CLS_NORM;
        e_in = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS);
    end

    always_comb begin
        stall       = out_valid_q && !out_ready;
        s1_v_d      = s1_v_q;
        s1_tag_d    = s1_tag_q;
        s1_sign_d   = s1_sign_q;
        s1_cls_d    = s1_cls_q;
        s1_ma_d     = s1_ma_q;
        s1_mb_d     = s1_mb_q;
        s1_e_d      = s1_e_q;
        s2_v_d      = s2_v_q;
        s2_tag_d    = s2_tag_q;
        s2_sign_d   = s2_sign_q;
        s2_cls_d    = s2_cls_q;
        s2_e_d      = s2_e_q;
        s2_prod_d   = s2_prod_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;
        out_tag_d   = out_tag_q;
        flags_d     = flags_q;
        if (!stall) begin
            s1_v_d    = in_valid;
            s1_tag_d  = in_tag;
            s1_sign_d = sa ^ sb;
            s1_cls_d  = cls_in;
            s1_ma_d   = {1'b1, fa};
            s1_mb_d   = {1'b1, fb};
            s1_e_d    = e_in;
            s2_v_d    = s1_v_q;
            s2_tag_d  = s1_tag_q;
            s2_sign_d = s1_sign_q;
            s2_cls_d  = s1_cls_q;
            s2_e_d    = s1_e_q;
            s2_prod_d = s1_ma_q * s1_mb_q;
            out_valid_d = s2_v_q;
            // Outputs only update on a real result so they stay quiet
            // across bubbles.
            if (s2_v_q) begin
                product_d = rp_res;
                out_tag_d = s2_tag_q;
                flags_d   = rp_flags;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            out_tag_q   <= '0;
            flags_q     <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s2_v_q      <= s2_v_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            out_tag_q   <= out_tag_d;
            flags_q     <= flags_d;
        end
    end

    always_ff @(posedge clock) begin
        s1_tag_q  <= s1_tag_d;
        s1_sign_q <= s1_sign_d;
        s1_cls_q  <= s1_cls_d;
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_e_q    <= s1_e_d;
        s2_tag_q  <= s2_tag_d;
        s2_sign_q <= s2_sign_d;
        s2_cls_q  <= s2_cls_d;
        s2_e_q    <= s2_e_d;
        s2_prod_q <= s2_prod_d;
    end

    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at half precision.
// Directed vectors with hand-computed results; monitor pops on transfer.
module tb_fp_mul_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall_seen = 0;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  f;
        logic [3:0]  t;
        int          issue;
        bit          lc;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    fp_mul_pipe #(
        .EXP_W (5),
        .MAN_W (10),
        .TAG_W (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            tests++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                fails++;
                $display("FAIL in_ready: got %b want %b at cyc %0d",
                         in_ready, !(out_valid && !out_ready), cyc);
            end
            if (out_valid === 1'b1 && !out_ready && in_ready === 1'b0)
                stall_seen++;
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected: result %h tag %0d",
                             product, out_tag);
                end else begin
                    m = sb.pop_front();
                    if (product !== m.p || flags !== m.f ||
                        out_tag !== m.t) begin
                        fails++;
                        $display("FAIL result tag%0d: got %h/%b/%0d want %h/%b/%0d",
                                 m.t, product, flags, out_tag,
                                 m.p, m.f, m.t);
                    end
                    if (m.lc) begin
                        tests++;
                        if (cyc != m.issue + 3) begin
                            fails++;
                            $display("FAIL latency: got %0d want 3",
                                     cyc - m.issue);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] t, input logic [15:0] ep,
                        input logic [3:0] ef, input bit lc);
        bit acc;
        int n;
        int iss;
        exp_t x;
        in_valid = 1'b1;
        opA      = a;
        opB      = b;
        in_tag   = t;
        acc      = 1'b0;
        n        = 0;
        iss      = 0;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = in_ready;
            iss = cyc;
            @(posedge clock);
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept tag%0d: in_ready stuck 0", t);
        end else begin
            x.p = ep; x.f = ef; x.t = t; x.issue = iss; x.lc = lc;
            sb.push_back(x);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        #1;
        tests++;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain %s: %0d results missing want 0",
                     nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string nm);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0
            || out_tag !== 4'h0 || flags !== 4'h0) begin
            fails++;
            $display("FAIL %s: got v%b r%b p%h t%h f%b want v0 r1 p0000 t0 f0000",
                     nm, out_valid, in_ready, product, out_tag, flags);
        end
    endtask

    logic [15:0] ba [8];
    logic [15:0] bb [8];
    logic [15:0] bp [8];

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_idle("reset_state");
        reset_n = 1'b1;

        send(16'h3C00, 16'h4000, 4'd3, 16'h4000, 4'b0000, 1'b1);
        idle(5);

        send(16'h3C01, 16'h3E00, 4'd1, 16'h3E02, 4'b0001, 1'b0);
        send(16'h3C01, 16'h3C01, 4'd2, 16'h3C02, 4'b0001, 1'b0);
        send(16'h7BFF, 16'h4000, 4'd4, 16'h7C00, 4'b0101, 1'b0);
        send(16'h0400, 16'h3800, 4'd5, 16'h0000, 4'b0011, 1'b0);
        send(16'h7C00, 16'h0000, 4'd6, 16'h7E00, 4'b1000, 1'b0);
        send(16'hFC00, 16'h4000, 4'd7, 16'hFC00, 4'b0000, 1'b0);
        send(16'h0000, 16'hFC00, 4'd8, 16'h7E00, 4'b1000, 1'b0);
        send(16'h7E01, 16'h3C00, 4'd9, 16'h7E00, 4'b1000, 1'b0);
        send(16'h8000, 16'h4000, 4'd10, 16'h8000, 4'b0000, 1'b0);
        send(16'h0001, 16'h4000, 4'd11, 16'h0000, 4'b0000, 1'b0);
        send(16'h3DA8, 16'h3DA8, 4'd12, 16'h4000, 4'b0001, 1'b0);
        send(16'h3FFF, 16'h3C01, 4'd13, 16'h4000, 4'b0001, 1'b0);
        wait_drain("directed");

        ba = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4200,
               16'hC000, 16'h3800, 16'h4400, 16'h0000};
        bb = '{16'h4000, 16'h4200, 16'h4000, 16'h4200,
               16'h3800, 16'h3800, 16'h4400, 16'h4000};
        bp = '{16'h4000, 16'h4200, 16'h4400, 16'h4880,
               16'hBC00, 16'h3400, 16'h4C00, 16'h0000};
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(ba[i], bb[i], 4'(i), bp[i], 4'b0000, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("burst");
        tests++;
        if (stall_seen == 0) begin
            fails++;
            $display("FAIL stall: in_ready low cycles got 0 want >0");
        end

        send(16'h3C00, 16'h4000, 4'd1, 16'h4000, 4'b0000, 1'b0);
        send(16'h4000, 16'h4000, 4'd2, 16'h4400, 4'b0000, 1'b0);
        send(16'h4200, 16'h4200, 4'd3, 16'h4880, 4'b0000, 1'b0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        check_idle("mid_reset");
        reset_n = 1'b1;
        idle(8);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: out_valid got %b want 0", out_valid);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, meaning stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of a sideband tag carried alongside each operation.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clock  input  1  rising-edge clock; reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 opA, opB  input  W each  IEEE-style operands {sign, exp, man}.
REQ-008 in_tag  input  TAG_W  sideband tag.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 product  output  W  packed result.
REQ-012 out_tag  output  TAG_W  tag of the accepted operation.
REQ-013 flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum; S2 (1+MAN_W)x(1+MAN_W) mantissa multiply; S3 normalise/round/pack.
REQ-015 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-016 stall = out_valid && !out_ready; in_ready = !stall; when stalled, all stage registers hold.
REQ-017 When not stalled all stages advance each cycle; empty stages propagate bubbles (valid=0).
REQ-018 Latency SHALL be exactly 3 cycles accept-to-out_valid with no stall; throughput one result per cycle.
REQ-019 Results SHALL leave in acceptance order with their own tag; product/flags/out_tag stable while out_valid&&!out_ready.
REQ-020 Sign = sA^sB for all results, including zero and inf; canonical NaN is sign 0, exp all-ones, man MSB 1, rest 0.
REQ-021 exp==0 operand SHALL be treated as zero (subnormal inputs flushed, no flag).
REQ-022 Either operand NaN, or inf x zero -> canonical NaN, invalid=1, other flags 0.
REQ-023 inf x non-zero finite -> signed inf, no flags.
REQ-024 zero x finite -> signed zero, no flags.
REQ-025 Unbiased exponent computed with EXP_W+2 signed bits: e = eA+eB-BIAS, BIAS = 2^(EXP_W-1)-1.
REQ-026 Product of width 2*MAN_W+2; if MSB set, shift right 1 and e+1.
REQ-027 Rounding SHALL be round-to-nearest-even using guard bit and OR-reduced sticky; inexact=1 if guard|sticky.
REQ-028 Rounding carry out of the mantissa SHALL renormalise (man=0, e+1) before the overflow check.
REQ-029 Final e >= all-ones exponent -> signed inf, overflow=1, inexact=1.
REQ-030 Final e <= 0 -> signed zero (no subnormal output), underflow=1, inexact=1.

Reset
REQ-031 While reset_n==0 at a rising edge, all stage valids SHALL clear; out_valid=0, in_ready=1, product=0, out_tag=0, flags=0 after that edge.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none emerge after reset release.
REQ-033 Datapath registers other than output registers need not be reset.

Structure
REQ-034 Shared package fp_pkg SHALL hold BIAS derivation, field-extract functions, flag struct type and canonical NaN/inf constants.
REQ-035 S3 normalise/round/pack SHALL be a sub-module fp_round_pack, combinational, parameterised by EXP_W/MAN_W.

Verification (defaults, half precision)
REQ-036 0x3C00 x 0x4000, tag 3 -> 0x4000, flags 0, tag 3, exactly 3 cycles later.
REQ-037 0x3C01 x 0x3E00 (tie) -> 0x3E02, inexact=1; 0x3C01 x 0x3C01 -> 0x3C02, inexact=1.
REQ-038 0x7BFF x 0x4000 -> 0x7C00, overflow=1, inexact=1; 0x0400 x 0x3800 -> 0x0000, underflow=1, inexact=1.
REQ-039 0x7C00 x 0x0000 -> 0x7E00, invalid=1; 0xFC00 x 0x4000 -> 0xFC00, no flags.
REQ-040 Back-to-back 8 ops with out_ready low cycles 4-7 -> in_ready low while stalled, all 8 results in order, none lost or duplicated.
REQ-041 reset_n low one cycle with 3 ops in flight -> out_valid 0 afterwards, no stale results emerge.
